mem_copy_engine: RTL

- Initiator-side master for the single-port main memory (5-bit address, 32-bit words, write committed on clk rising edge, read data updated on clk falling edge).
- On a start pulse it either copies a block of words from a source to a destination region, or fills a region with a constant.
- It drives the memory's address, read/write strobes and write data, and returns read data through the memory's output bus.
- It sits beside the processor datapath as a block-move/clear helper and owns the memory port while busy.

---
 rtl/mem_copy_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block copy / fill master for the single-port main memory
// Copies ascending from src to dst, or fills dst with a constant; owns the memory port while busy.
module mem_copy_engine #(
    parameter int WORD_SIZE   = 32,
    parameter int MEMORY_BITS = 5,
    parameter int MEMORY_SIZE = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [MEMORY_BITS-1:0] src_addr,
    input  logic [MEMORY_BITS-1:0] dst_addr,
    input  logic [MEMORY_BITS:0]   length,
    input  logic [WORD_SIZE-1:0]   fill_data,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [MEMORY_BITS:0]   words_done,
    output logic [MEMORY_BITS-1:0] mem_address,
    output logic                   mem_read_signal,
    output logic                   mem_write_signal,
    output logic [WORD_SIZE-1:0]   mem_write_data,
    input  logic [WORD_SIZE-1:0]   mem_read_data
);

    localparam logic [MEMORY_BITS:0] MAX_LEN = (MEMORY_BITS+1)'(MEMORY_SIZE);
    localparam logic [MEMORY_BITS:0] ONE     = (MEMORY_BITS+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE
    } state_t;

    state_t                 state_q, state_d;
    logic [MEMORY_BITS-1:0] src_q, src_d;
    logic [MEMORY_BITS-1:0] dst_q, dst_d;
    logic                   mode_q, mode_d;
    logic [WORD_SIZE-1:0]   fill_q, fill_d;
    logic [MEMORY_BITS:0]   len_q, len_d;
    logic [MEMORY_BITS:0]   idx_q, idx_d;
    logic [MEMORY_BITS:0]   words_done_q, words_done_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic [MEMORY_BITS-1:0] addr_q, addr_d;
    // Write-data register doubles as the copy buffer: it holds the word read in READ.
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;

    logic [MEMORY_BITS:0]   len_clamped;
    logic [MEMORY_BITS:0]   idx_inc;
    logic [MEMORY_BITS-1:0] cur_off;
    logic [MEMORY_BITS-1:0] next_off;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign idx_inc     = idx_q + ONE;
    assign cur_off     = idx_q[MEMORY_BITS-1:0];
    assign next_off    = idx_inc[MEMORY_BITS-1:0];

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        mode_d       = mode_q;
        fill_d       = fill_q;
        len_d        = len_q;
        idx_d        = idx_q;
        words_done_d = words_done_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        rd_d         = 1'b0;
        wr_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    mode_d       = mode;
                    fill_d       = fill_data;
                    len_d        = len_clamped;
                    idx_d        = '0;
                    words_done_d = '0;
                    if (len_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        if (mode) begin
                            state_d = S_WRITE;
                            wr_d    = 1'b1;
                            addr_d  = dst_addr;
                            wdata_d = fill_data;
                        end else begin
                            state_d = S_READ;
                            rd_d    = 1'b1;
                            addr_d  = src_addr;
                        end
                    end
                end
            end

            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_WRITE;
                    wr_d    = 1'b1;
                    addr_d  = dst_q + cur_off;
                    wdata_d = mem_read_data;
                end
            end

            S_WRITE: begin
                // The memory commits this word at the edge regardless of abort.
                idx_d        = idx_inc;
                words_done_d = words_done_q + ONE;
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (idx_inc == len_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (mode_q) begin
                    wr_d    = 1'b1;
                    addr_d  = dst_q + next_off;
                    wdata_d = fill_q;
                end else begin
                    state_d = S_READ;
                    rd_d    = 1'b1;
                    addr_d  = src_q + next_off;
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            mode_q       <= 1'b0;
            fill_q       <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            words_done_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            mode_q       <= mode_d;
            fill_q       <= fill_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            words_done_q <= words_done_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign words_done       = words_done_q;
    assign mem_address      = addr_q;
    assign mem_read_signal  = rd_q;
    assign mem_write_signal = wr_q;
    assign mem_write_data   = wdata_q;

endmodule
